// File: rtl/network_mac_pipe.sv
// network_mac_pipe
//   Pipelined multiply-accumulate unit with framed accumulation and a
//   requantising output stage (round-half-up, arithmetic shift, saturate).
//   Each beat's product enters a frame accumulator. A frame's last beat
//   produces one result.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   ce         clock enable; every register holds while low
//   in_valid   din0/din1/in_first/in_last qualify this cycle
//   in_first   first beat of a frame (accumulator loads)
//   in_last    last beat of a frame (produces a result)
//   din0       signed operand a, A_WIDTH bits
//   din1       operand b, B_WIDTH bits, signed when B_SIGNED=1
//   out_valid  dout valid for one ce-cycle
//   dout       rounded, shifted, saturated frame result
//   sat_flag   dout was clipped (qualified by out_valid)
module network_mac_pipe #(
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 12,
    parameter int B_SIGNED  = 0,
    parameter int NUM_STAGE = 3,
    parameter int ACC_WIDTH = 40,
    parameter int SHIFT     = 12,
    parameter int OUT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        ce,
    input  logic                        in_valid,
    input  logic                        in_first,
    input  logic                        in_last,
    input  logic signed [A_WIDTH-1:0]   din0,
    input  logic        [B_WIDTH-1:0]   din1,
    output logic                        out_valid,
    output logic signed [OUT_WIDTH-1:0] dout,
    output logic                        sat_flag
);

    // One extra bit keeps the signed product exact for either b signedness.
    localparam int P_WIDTH = A_WIDTH + B_WIDTH + 1;
    localparam int DLY     = NUM_STAGE - 1;

    localparam logic signed [ACC_WIDTH:0] RND =
        (ACC_WIDTH+1)'(SHIFT > 0) << ((SHIFT > 0) ? SHIFT - 1 : 0);
    localparam logic signed [ACC_WIDTH:0] SAT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] SAT_MIN = ~SAT_MAX;
    localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    // Stage 1: input registers
    logic signed [A_WIDTH-1:0]   r_a;
    logic        [B_WIDTH-1:0]   r_b;
    logic                        r_v1;
    logic                        r_f1;
    logic                        r_l1;

    // Stages 2..NUM_STAGE: product delay line
    logic signed [P_WIDTH-1:0]   r_p [DLY];
    logic        [DLY-1:0]       r_pv;
    logic        [DLY-1:0]       r_pf;
    logic        [DLY-1:0]       r_pl;

    // Stage NUM_STAGE+1: accumulator
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic                        r_ol;

    logic signed [P_WIDTH-1:0]   w_a_ext;
    logic signed [P_WIDTH-1:0]   w_b_ext;
    logic signed [P_WIDTH-1:0]   w_prod;
    logic signed [ACC_WIDTH-1:0] w_p_acc;
    logic signed [ACC_WIDTH-1:0] w_acc_new;
    logic signed [ACC_WIDTH:0]   w_round;
    logic signed [ACC_WIDTH:0]   w_shift;
    logic        [OUT_WIDTH-1:0] w_sat;
    logic                        w_clip;

    always_comb begin
        w_a_ext = P_WIDTH'(r_a);
        if (B_SIGNED != 0) begin
            w_b_ext = P_WIDTH'($signed(r_b));
        end else begin
            w_b_ext = P_WIDTH'($signed({1'b0, r_b}));
        end
        w_prod    = w_a_ext * w_b_ext;
        w_p_acc   = ACC_WIDTH'(r_p[DLY-1]);
        w_acc_new = r_pf[DLY-1] ? w_p_acc : r_acc + w_p_acc;
    end

    // Requantise the accumulator; r_acc already holds the frame total when
    // r_ol is set, because both were written on the same ce edge.
    always_comb begin
        w_round = $signed({r_acc[ACC_WIDTH-1], r_acc}) + RND;
        w_shift = w_round >>> SHIFT;
        w_clip  = 1'b0;
        w_sat   = w_shift[OUT_WIDTH-1:0];
        if (w_shift > SAT_MAX) begin
            w_sat  = OUT_MAX;
            w_clip = 1'b1;
        end else if (w_shift < SAT_MIN) begin
            w_sat  = OUT_MIN;
            w_clip = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_v1  <= 1'b0;
            r_f1  <= 1'b0;
            r_l1  <= 1'b0;
            for (int unsigned i = 0; i < DLY; i++) begin
                r_p[i] <= '0;
            end
            r_pv      <= '0;
            r_pf      <= '0;
            r_pl      <= '0;
            r_acc     <= '0;
            r_ol      <= 1'b0;
            out_valid <= 1'b0;
            dout      <= '0;
            sat_flag  <= 1'b0;
        end else if (ce) begin
            r_a  <= din0;
            r_b  <= din1;
            r_v1 <= in_valid;
            r_f1 <= in_valid & in_first;
            r_l1 <= in_valid & in_last;

            r_p[0]  <= w_prod;
            r_pv[0] <= r_v1;
            r_pf[0] <= r_f1;
            r_pl[0] <= r_l1;
            for (int unsigned i = 1; i < DLY; i++) begin
                r_p[i]  <= r_p[i-1];
                r_pv[i] <= r_pv[i-1];
                r_pf[i] <= r_pf[i-1];
                r_pl[i] <= r_pl[i-1];
            end

            if (r_pv[DLY-1]) begin
                r_acc <= w_acc_new;
            end
            r_ol <= r_pv[DLY-1] & r_pl[DLY-1];

            out_valid <= r_ol;
            if (r_ol) begin
                dout     <= w_sat;
                sat_flag <= w_clip;
            end
        end
    end

endmodule

// File: tb/tb_network_mac_pipe.sv
// tb_network_mac_pipe
//   Drives two instances from one stimulus stream: u0 with default
//   parameters, u1 with B_SIGNED=1 and NUM_STAGE=2. A frame-level reference
//   model predicts each result and the ce-cycle it must appear on.
module tb_network_mac_pipe;

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b0;
    logic        ce       = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_first = 1'b0;
    logic        in_last  = 1'b0;
    logic [15:0] din0     = '0;
    logic [11:0] din1     = '0;
    logic        ov0, ov1, s0, s1;
    logic [15:0] d0, d1;

    network_mac_pipe u0 (
        .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid),
        .in_first(in_first), .in_last(in_last), .din0(din0), .din1(din1),
        .out_valid(ov0), .dout(d0), .sat_flag(s0)
    );

    network_mac_pipe #(.B_SIGNED(1), .NUM_STAGE(2)) u1 (
        .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid),
        .in_first(in_first), .in_last(in_last), .din0(din0), .din1(din1),
        .out_valid(ov1), .dout(d1), .sat_flag(s1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic        s;
        int          cyc;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [16:0] obs0[$];
    logic [16:0] obs1[$];
    int          tests = 0;
    int          fails = 0;
    int          cnt   = 0;
    bit          edge_ce = 1'b0;
    bit          mon_en  = 1'b0;
    longint      macc0 = 0;
    longint      macc1 = 0;
    longint      p0, p1;
    logic        pv [2] = '{1'b0, 1'b0};
    logic [15:0] pd [2] = '{16'h0, 16'h0};
    logic        ps [2] = '{1'b0, 1'b0};
    int          lat0, lat1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint prod(input bit bsgn, input logic [15:0] a, input logic [11:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        if (bsgn) sb = longint'($signed(b));
        else      sb = longint'(b);
        return sa * sb;
    endfunction

    function automatic longint wrap40(input longint x);
        return (x <<< 24) >>> 24;
    endfunction

    function automatic exp_t requant(input longint acc, input int cyc);
        exp_t   e;
        longint r;
        r = (acc + 2048) >>> 12;
        if (r > 32767) begin
            e.d = 16'h7fff; e.s = 1'b1;
        end else if (r < -32768) begin
            e.d = 16'h8000; e.s = 1'b1;
        end else begin
            e.d = 16'(r);   e.s = 1'b0;
        end
        e.cyc = cyc;
        return e;
    endfunction

    // Results appear NUM_STAGE+1 ce edges after the edge accepting the last beat.
    always @(posedge clk) begin
        edge_ce = reset_n && ce;
        if (edge_ce) begin
            cnt++;
            if (in_valid) begin
                p0 = prod(1'b0, din0, din1);
                p1 = prod(1'b1, din0, din1);
                macc0 = in_first ? p0 : wrap40(macc0 + p0);
                macc1 = in_first ? p1 : wrap40(macc1 + p1);
                if (in_last) begin
                    q0.push_back(requant(macc0, cnt + 4));
                    q1.push_back(requant(macc1, cnt + 3));
                end
            end
        end
    end

    always @(negedge reset_n) begin
        q0.delete();
        q1.delete();
        macc0 = 0;
        macc1 = 0;
        pv = '{1'b0, 1'b0};
        pd = '{16'h0, 16'h0};
        ps = '{1'b0, 1'b0};
    end

    // ---------------- output monitor ----------------
    task automatic mon(input int i, input logic v, input logic [15:0] d, input logic s);
        exp_t e;
        bit   due;
        if (edge_ce) begin
            if (i == 0) due = (q0.size() > 0) && (q0[0].cyc == cnt);
            else        due = (q1.size() > 0) && (q1[0].cyc == cnt);
            if (due) begin
                if (i == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk($sformatf("u%0d.out_valid", i), 64'(v), 64'(1'b1));
                chk($sformatf("u%0d.dout", i), 64'(d), 64'(e.d));
                chk($sformatf("u%0d.sat_flag", i), 64'(s), 64'(e.s));
            end else begin
                chk($sformatf("u%0d.no_pulse", i), 64'(v), 64'(1'b0));
            end
            if (v) begin
                if (i == 0) obs0.push_back({s, d});
                else        obs1.push_back({s, d});
            end
        end else begin
            chk($sformatf("u%0d.hold", i), 64'({v, s, d}), 64'({pv[i], ps[i], pd[i]}));
        end
        pv[i] = v;
        pd[i] = d;
        ps[i] = s;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, ov0, d0, s0);
            mon(1, ov1, d1, s1);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic beat(input logic [15:0] a, input logic [11:0] b, input logic f, input logic l);
        in_valid = 1'b1;
        in_first = f;
        in_last  = l;
        din0     = a;
        din1     = b;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic rbeat(input logic v, input logic f, input logic l,
                         input logic [15:0] a, input logic [11:0] b);
        in_valid = v;
        in_first = f;
        in_last  = l;
        din0     = a;
        din1     = b;
        do begin
            ce = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end while (!ce);
    endtask

    task automatic wait_out(output int l0, output int l1);
        l0 = 0;
        l1 = 0;
        for (int c = 1; c <= 12; c++) begin
            if (ov0 && l0 == 0) l0 = c;
            if (ov1 && l1 == 0) l1 = c;
            if (l0 != 0 && l1 != 0) break;
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        repeat (2) @(negedge clk);
        chk("reset.u0.out_valid", 64'(ov0), 64'(1'b0));
        chk("reset.u0.dout", 64'(d0), 64'(16'h0));
        chk("reset.u0.sat_flag", 64'(s0), 64'(1'b0));
        chk("reset.u1.out_valid", 64'(ov1), 64'(1'b0));
        chk("reset.u1.dout", 64'(d1), 64'(16'h0));
        chk("reset.u1.sat_flag", 64'(s1), 64'(1'b0));
        reset_n = 1'b1;
        ce      = 1'b1;
        mon_en  = 1'b1;
        idle(2);

        // single-beat frame, latency, and stretch of out_valid under ce=0
        beat(16'hFFFD, 12'd4095, 1'b1, 1'b1);
        in_valid = 1'b0;
        wait_out(lat0, lat1);
        chk("t1.latency_u0", 64'(lat0), 64'd5);
        chk("t1.latency_u1", 64'(lat1), 64'd4);
        chk("t1.dout", 64'(d0), 64'(16'hFFFD));
        chk("t1.sat_flag", 64'(s0), 64'(1'b0));
        ce = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("t1.stretch", 64'(ov0), 64'(1'b1));
        end
        ce = 1'b1;
        @(negedge clk);
        chk("t1.pulse_end", 64'(ov0), 64'(1'b0));
        idle(8);

        // 4-beat frame
        obs0.delete();
        beat(16'd1000, 12'd4095, 1'b1, 1'b0);
        beat(16'd1000, 12'd4095, 1'b0, 1'b0);
        beat(16'd1000, 12'd4095, 1'b0, 1'b0);
        beat(16'd1000, 12'd4095, 1'b0, 1'b1);
        idle(10);
        chk("t2.pulses", 64'(obs0.size()), 64'd1);
        chk("t2.result", 64'(obs0[0]), 64'({1'b0, 16'h0F9F}));

        // positive then negative saturation, back to back
        obs0.delete();
        for (int k = 0; k < 4; k++) beat(16'h7FFF, 12'd4095, 1'(k == 0), 1'(k == 3));
        for (int k = 0; k < 4; k++) beat(16'h8000, 12'd4095, 1'(k == 0), 1'(k == 3));
        idle(10);
        chk("t3.pulses", 64'(obs0.size()), 64'd2);
        chk("t3.pos_sat", 64'(obs0[0]), 64'({1'b1, 16'h7FFF}));
        chk("t3.neg_sat", 64'(obs0[1]), 64'({1'b1, 16'h8000}));

        // back-to-back 2-beat frames with a ce stall mid-frame
        obs0.delete();
        beat(16'd1, 12'd4095, 1'b1, 1'b0);
        beat(16'd1, 12'd4095, 1'b0, 1'b1);
        beat(16'd2, 12'd4095, 1'b1, 1'b0);
        in_first = 1'b0;
        in_last  = 1'b1;
        ce = 1'b0;
        repeat (3) @(negedge clk);
        ce = 1'b1;
        beat(16'd2, 12'd4095, 1'b0, 1'b1);
        idle(10);
        chk("t4.pulses", 64'(obs0.size()), 64'd2);
        chk("t4.first", 64'(obs0[0]), 64'({1'b0, 16'd2}));
        chk("t4.second", 64'(obs0[1]), 64'({1'b0, 16'd4}));

        // asynchronous reset with a frame in flight
        obs0.delete();
        beat(16'd1000, 12'd4095, 1'b1, 1'b0);
        beat(16'd1000, 12'd4095, 1'b0, 1'b0);
        beat(16'd1000, 12'd4095, 1'b0, 1'b1);
        idle(1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5.async_dout", 64'(d0), 64'(16'h0));
        chk("t5.async_valid", 64'(ov0), 64'(1'b0));
        chk("t5.async_u1_dout", 64'(d1), 64'(16'h0));
        @(negedge clk);
        reset_n = 1'b1;
        idle(10);
        chk("t5.no_output", 64'(obs0.size()), 64'd0);
        beat(16'd1, 12'd4095, 1'b1, 1'b1);
        idle(8);
        chk("t5.after_pulses", 64'(obs0.size()), 64'd1);
        chk("t5.after_result", 64'(obs0[0]), 64'({1'b0, 16'd1}));

        // signed b on the short pipeline
        beat(16'hFFFE, 12'hFFF, 1'b1, 1'b1);
        in_valid = 1'b0;
        wait_out(lat0, lat1);
        chk("t6.latency_u1", 64'(lat1), 64'd4);
        chk("t6.latency_u0", 64'(lat0), 64'd5);
        chk("t6.u1_dout", 64'(d1), 64'(16'h0));
        chk("t6.u1_sat", 64'(s1), 64'(1'b0));
        idle(8);

        // randomized frames, bubbles, stalls and occasional missing first beat
        for (int f = 0; f < 40; f++) begin
            int nb;
            bit nofirst;
            nb      = $urandom_range(1, 6);
            nofirst = ($urandom_range(0, 9) == 0);
            for (int k = 0; k < nb; k++) begin
                if ($urandom_range(0, 4) == 0)
                    rbeat(1'b0, 1'($urandom), 1'($urandom), 16'($urandom), 12'($urandom));
                rbeat(1'b1, 1'((k == 0) && !nofirst), 1'(k == nb - 1),
                      16'($urandom), 12'($urandom));
            end
        end
        ce = 1'b1;
        idle(1);
        for (int c = 0; c < 50 && (q0.size() != 0 || q1.size() != 0); c++) @(negedge clk);
        chk("drain.u0", 64'(q0.size()), 64'd0);
        chk("drain.u1", 64'(q1.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
